hazard_scoreboard_pipe: RTL and testbench

Parametrised issue/hazard unit for the pipelined core, generalising the fixed three-register stall chain to DEPTH in-flight stages. It tracks the destination register of every in-flight instruction and holds issue on RAW or WAW hazards. It injects bubbles (all-zero NO-OP) when stalled or flushed and presents per-stage instruction words to downstream control. It also exposes the retiring entry and a stall-cycle counter.

---
 rtl/hazard_scoreboard_pipe.sv | 142 ++++++++++++++
 tb/tb_hazard_scoreboard_pipe.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_pipe.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard_pipe
// Purpose  : Issue/hazard unit for a pipelined core. It tracks the destination
//            register of each of DEPTH in-flight stages and holds issue on RAW
//            or WAW hazards. When an instruction is not accepted, an all-zero
//            bubble is injected instead. Entries always advance; the
//            downstream pipe never stalls.
// Ports    : clk, rst (sync, active-high)
//            issue_*       : candidate instruction, its dst and two sources
//            flush         : squash the current issue slot
//            issue_ready   : instruction accepted this cycle
//            stage_valid / stage_instr : per-entry state, entry k at slice k
//            busy          : per-register in-flight-writer flags
//            retire_valid / retire_dst : write-back entry (DEPTH-1)
//            fwd0 / fwd1   : operand served by write-back bypass
//            stall_cycles  : saturating count of stalled cycles
// Options  : HAZARD_FORWARD_EN - when defined, the write-back entry is left
//            out of RAW detection and reported on fwd0/fwd1 instead.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard_pipe #(
    parameter int INSTR_W = 32,
    parameter int REG_AW  = 5,
    parameter int DEPTH   = 3,
    parameter int CNT_W   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    input  logic [INSTR_W-1:0]       issue_instr,
    input  logic                     issue_dst_vld,
    input  logic [REG_AW-1:0]        issue_dst,
    input  logic                     issue_src0_vld,
    input  logic                     issue_src1_vld,
    input  logic [REG_AW-1:0]        issue_src0,
    input  logic [REG_AW-1:0]        issue_src1,
    input  logic                     flush,
    output logic                     issue_ready,
    output logic [DEPTH-1:0]         stage_valid,
    output logic [DEPTH*INSTR_W-1:0] stage_instr,
    output logic [2**REG_AW-1:0]     busy,
    output logic                     retire_valid,
    output logic [REG_AW-1:0]        retire_dst,
    output logic                     fwd0,
    output logic                     fwd1,
    output logic [CNT_W-1:0]         stall_cycles
);

    localparam int c_NREG = 2**REG_AW;

    // Entry state; index 0 is the youngest, DEPTH-1 is write-back.
    logic [DEPTH-1:0]              r_valid;
    logic [DEPTH-1:0]              r_dst_vld;
    logic [DEPTH-1:0][REG_AW-1:0]  r_dst;
    logic [DEPTH-1:0][INSTR_W-1:0] r_instr;
    logic [CNT_W-1:0]              r_stall_cnt;

    logic [c_NREG-1:0] w_busy;      // every in-flight writer (WAW + output)
    logic [c_NREG-1:0] w_busy_raw;  // writers that block a source read
    logic              w_hazard;
    logic              w_ready;
    logic              w_stall;

    always_comb begin
        w_busy     = '0;
        w_busy_raw = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (r_valid[k] && r_dst_vld[k]) begin
                w_busy[r_dst[k]] = 1'b1;
`ifdef HAZARD_FORWARD_EN
                // Write-back value reaches the reader through the bypass.
                if (k != DEPTH-1) begin
                    w_busy_raw[r_dst[k]] = 1'b1;
                end
`else
                w_busy_raw[r_dst[k]] = 1'b1;
`endif
            end
        end
    end

    // WAW always uses the full busy set so a register never has two writers.
    assign w_hazard = (issue_src0_vld & w_busy_raw[issue_src0])
                    | (issue_src1_vld & w_busy_raw[issue_src1])
                    | (issue_dst_vld  & w_busy[issue_dst]);

    // flush wins over a hazard: the slot is squashed, not stalled.
    assign w_ready = issue_valid & ~w_hazard & ~flush;
    assign w_stall = issue_valid &  w_hazard & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= '0;
            r_dst_vld   <= '0;
            r_dst       <= '0;
            r_instr     <= '0;
            r_stall_cnt <= '0;
        end else begin
            for (int k = 1; k < DEPTH; k++) begin
                r_valid[k]   <= r_valid[k-1];
                r_dst_vld[k] <= r_dst_vld[k-1];
                r_dst[k]     <= r_dst[k-1];
                r_instr[k]   <= r_instr[k-1];
            end
            if (w_ready) begin
                r_valid[0]   <= 1'b1;
                r_dst_vld[0] <= issue_dst_vld;
                r_dst[0]     <= issue_dst;
                r_instr[0]   <= issue_instr;
            end else begin
                r_valid[0]   <= 1'b0;
                r_dst_vld[0] <= 1'b0;
                r_dst[0]     <= '0;
                r_instr[0]   <= '0;
            end
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign issue_ready  = w_ready;
    assign stage_valid  = r_valid;
    assign stage_instr  = r_instr;   // packed: entry k lands at [k*INSTR_W +: INSTR_W]
    assign busy         = w_busy;
    assign retire_valid = r_valid[DEPTH-1] & r_dst_vld[DEPTH-1];
    assign retire_dst   = r_dst[DEPTH-1];
    assign stall_cycles = r_stall_cnt;

`ifdef HAZARD_FORWARD_EN
    assign fwd0 = issue_src0_vld & r_valid[DEPTH-1] & r_dst_vld[DEPTH-1]
                & (r_dst[DEPTH-1] == issue_src0);
    assign fwd1 = issue_src1_vld & r_valid[DEPTH-1] & r_dst_vld[DEPTH-1]
                & (r_dst[DEPTH-1] == issue_src1);
`else
    assign fwd0 = 1'b0;
    assign fwd1 = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard_pipe
// Purpose  : Directed self-checking bench for hazard_scoreboard_pipe with
//            DEPTH=3 and a 4-bit stall counter so saturation is reachable.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard_pipe;

    localparam int c_INSTR_W = 32;
    localparam int c_REG_AW  = 5;
    localparam int c_DEPTH   = 3;
    localparam int c_CNT_W   = 4;
`ifdef HAZARD_FORWARD_EN
    localparam int c_FWD = 1;
`else
    localparam int c_FWD = 0;
`endif

    logic                         clk;
    logic                         rst;
    logic                         issue_valid;
    logic [c_INSTR_W-1:0]         issue_instr;
    logic                         issue_dst_vld;
    logic [c_REG_AW-1:0]          issue_dst;
    logic                         issue_src0_vld;
    logic                         issue_src1_vld;
    logic [c_REG_AW-1:0]          issue_src0;
    logic [c_REG_AW-1:0]          issue_src1;
    logic                         flush;
    logic                         issue_ready;
    logic [c_DEPTH-1:0]           stage_valid;
    logic [c_DEPTH*c_INSTR_W-1:0] stage_instr;
    logic [2**c_REG_AW-1:0]       busy;
    logic                         retire_valid;
    logic [c_REG_AW-1:0]          retire_dst;
    logic                         fwd0;
    logic                         fwd1;
    logic [c_CNT_W-1:0]           stall_cycles;

    int n_checks;
    int n_fail;

    hazard_scoreboard_pipe #(
        .INSTR_W (c_INSTR_W),
        .REG_AW  (c_REG_AW),
        .DEPTH   (c_DEPTH),
        .CNT_W   (c_CNT_W)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid    (issue_valid),
        .issue_instr    (issue_instr),
        .issue_dst_vld  (issue_dst_vld),
        .issue_dst      (issue_dst),
        .issue_src0_vld (issue_src0_vld),
        .issue_src1_vld (issue_src1_vld),
        .issue_src0     (issue_src0),
        .issue_src1     (issue_src1),
        .flush          (flush),
        .issue_ready    (issue_ready),
        .stage_valid    (stage_valid),
        .stage_instr    (stage_instr),
        .busy           (busy),
        .retire_valid   (retire_valid),
        .retire_dst     (retire_dst),
        .fwd0           (fwd0),
        .fwd1           (fwd1),
        .stall_cycles   (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic dv,
                         input logic [4:0] d, input logic s0v, input logic [4:0] s0,
                         input logic s1v, input logic [4:0] s1, input logic fl);
        issue_valid    = v;
        issue_instr    = ins;
        issue_dst_vld  = dv;
        issue_dst      = d;
        issue_src0_vld = s0v;
        issue_src0     = s0;
        issue_src1_vld = s1v;
        issue_src1     = s1;
        flush          = fl;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        #1;
        check({tag, "_valid"},  64'(stage_valid), 64'h0);
        check({tag, "_instr"},  64'(stage_instr[63:0]) | 64'(stage_instr[95:64]), 64'h0);
        check({tag, "_busy"},   64'(busy), 64'h0);
        check({tag, "_retire"}, {62'h0, retire_valid, |retire_dst}, 64'h0);
        check({tag, "_cnt"},    64'(stall_cycles), 64'h0);
        check({tag, "_ready"},  {62'h0, issue_ready, fwd0 | fwd1}, 64'h0);
    endtask

    initial begin
        int n;
        logic [31:0] exp_busy [8];
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        idle();
        step();
        step();
        rst = 1'b0;
        check_all_zero("reset");

        // ---------------- RAW: writer r5, then reader of r5 ----------------
        drive(1'b1, 32'hA5A5_0005, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        check("raw_writer_ready", 64'(issue_ready), 64'h1);
        step();
        drive(1'b1, 32'h0000_0606, 1'b1, 5'd6, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0);
        n = 0;
        #1;
        while (!issue_ready && n < 10) begin
            if (n == 1) begin
                check("raw_bubble_stage", 64'(stage_instr[63:0]), 64'hA5A5_0005_0000_0000);
                check("raw_busy", 64'(busy), 64'h20);
            end
            step();
            n++;
            #1;
        end
        check("raw_stall_len", 64'(n), 64'(3 - c_FWD));
        check("raw_stall_cnt", 64'(stall_cycles), 64'(3 - c_FWD));
        check("raw_fwd0", 64'(fwd0), 64'(c_FWD));
        step();
        idle();
        step(); step(); step(); step();

        // ---------------- independent stream r1..r4 ----------------
        do_reset();
        exp_busy = '{32'h0, 32'h2, 32'h6, 32'hE, 32'h1C, 32'h18, 32'h10, 32'h0};
        for (int c = 0; c < 8; c++) begin
            if (c < 4) drive(1'b1, 32'h100 + 32'(c), 1'b1, 5'(c + 1), 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
            else       idle();
            #1;
            if (c < 4) check($sformatf("stream_ready%0d", c), 64'(issue_ready), 64'h1);
            check($sformatf("stream_busy%0d", c), 64'(busy), 64'(exp_busy[c]));
            check($sformatf("stream_retv%0d", c), 64'(retire_valid), (c >= 3 && c <= 6) ? 64'h1 : 64'h0);
            if (c >= 3 && c <= 6) check($sformatf("stream_retd%0d", c), 64'(retire_dst), 64'(c - 2));
            step();
        end

        // ---------------- WAW on r7 ----------------
        do_reset();
        drive(1'b1, 32'h0777_0001, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        // src0 names r7 but is marked unused: must not stall or forward.
        drive(1'b1, 32'h0777_0002, 1'b1, 5'd7, 1'b0, 5'd7, 1'b0, 5'd0, 1'b0);
        n = 0;
        #1;
        while (!issue_ready && n < 10) begin
            check($sformatf("waw_busy%0d", n), 64'(busy), 64'h80);
            if (n == 2) check("waw_nofwd", {62'h0, fwd0, fwd1}, 64'h0);
            step();
            n++;
            #1;
        end
        check("waw_stall_len", 64'(n), 64'h3);
        step();
        check("waw_second_writer", 64'(stage_instr[31:0]), 64'h0777_0002);
        idle();
        step(); step(); step();

        // ---------------- flush and idle slot with hazard ----------------
        do_reset();
        drive(1'b1, 32'h0000_0055, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        drive(1'b1, 32'h0000_0066, 1'b1, 5'd6, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1);
        #1;
        check("flush_ready", 64'(issue_ready), 64'h0);
        step();
        check("flush_stage_valid", 64'(stage_valid), 64'h2);
        check("flush_cnt", 64'(stall_cycles), 64'h0);
        drive(1'b0, 32'h0000_0066, 1'b1, 5'd6, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0);
        #1;
        check("novalid_ready", 64'(issue_ready), 64'h0);
        step();
        check("novalid_cnt", 64'(stall_cycles), 64'h0);

        // ---------------- counter saturation, then reset ----------------
        do_reset();
        drive(1'b1, 32'h0000_0333, 1'b1, 5'd3, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0);
        for (int c = 0; c < 28; c++) step();
        check("sat_cnt", 64'(stall_cycles), 64'hF);
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_all_zero("midreset");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
